// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shift-add MUL and
// restoring DIVU, with valid/ready handshakes on both request and result sides.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div, b_zero;
  logic [WIDTH-1:0] acc;          // MUL partial product
  logic [WIDTH:0]   rem;          // DIVU partial remainder (extra bit = trial sign)
  logic [WIDTH-1:0] opa;          // MUL multiplier (shifts right) / DIVU dividend->quotient
  logic [WIDTH-1:0] opb;          // MUL multiplicand (shifts left) / DIVU divisor
  logic [WIDTH-1:0] result_q;
  logic             zero_q, dbz_q;

  logic             multi, last;
  logic [WIDTH-1:0] single_res, mul_acc_nxt, div_quot_nxt, busy_res;
  logic [WIDTH:0]   div_shift, div_trial, div_rem_nxt;
  logic             div_ok;

  assign multi = (alu_control[2:1] == 2'b11);
  assign last  = (cnt == CW'(WIDTH - 1));

  always_comb begin
    single_res = '0;
    case (alu_control)
      3'b000:  single_res = a + b;
      3'b001:  single_res = a - b;
      3'b010:  single_res = a & b;
      3'b011:  single_res = a | b;
      3'b100:  single_res = b;
      3'b101:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: single_res = '0;
    endcase
  end

  // One iteration of each multi-cycle algorithm; the final one feeds result directly.
  always_comb begin
    mul_acc_nxt  = opa[0] ? (acc + opb) : acc;
    div_shift    = {rem[WIDTH-1:0], opa[WIDTH-1]};
    div_trial    = div_shift - {1'b0, opb};
    div_ok       = ~div_trial[WIDTH];
    div_rem_nxt  = div_ok ? div_trial : div_shift;
    div_quot_nxt = {opa[WIDTH-2:0], div_ok};
    busy_res     = is_div ? (b_zero ? '1 : div_quot_nxt) : mul_acc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = multi ? BUSY : DONE;
      end
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      b_zero   <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      opa      <= '0;
      opb      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (multi) begin
            is_div <= alu_control[0];
            b_zero <= alu_control[0] && (b == '0);
            opa    <= alu_control[0] ? a : b;
            opb    <= alu_control[0] ? b : a;
            acc    <= '0;
            rem    <= '0;
            cnt    <= '0;
          end else begin
            result_q <= single_res;
            zero_q   <= (single_res == '0);
            dbz_q    <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            rem <= div_rem_nxt;
            opa <= div_quot_nxt;
          end else begin
            acc <= mul_acc_nxt;
            opa <= opa >> 1;
            opb <= opb << 1;
          end
          if (last) begin
            result_q <= busy_res;
            zero_q   <= (busy_res == '0);
            dbz_q    <= is_div && b_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign result      = result_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 4..64).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operation request valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 SHALL have port a, input, WIDTH, operand A.
REQ-007 SHALL have port b, input, WIDTH, operand B.
REQ-008 SHALL have port alu_control, input, 3, opcode.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port result, output, WIDTH, operation result.
REQ-012 SHALL have port zero, output, 1, high when result is all zeros.
REQ-013 SHALL have port div_by_zero, output, 1, high when a completed DIVU had b == 0.

Function
REQ-014 SHALL decode opcodes: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 PASS b; 101 SLT signed (result 1 if $signed(a) < $signed(b), else 0); 110 MUL, low WIDTH bits of a*b; 111 DIVU, unsigned quotient a/b.
REQ-015 SHALL wrap ADD, SUB and MUL modulo 2^WIDTH, with no carry or overflow output.
REQ-016 SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-017 SHALL drive in_ready high only in IDLE; a request is accepted on the edge where in_valid && in_ready.
REQ-018 SHALL, for single-cycle opcodes 000-101, go IDLE->DONE on acceptance, registering result so out_valid rises one cycle after acceptance.
REQ-019 SHALL, for MUL and DIVU, latch the operands and go IDLE->BUSY on acceptance.
REQ-020 SHALL run MUL in BUSY as an iterative shift-add, one multiplier bit per cycle.
REQ-021 SHALL run DIVU in BUSY as an iterative restoring division, one quotient bit per cycle.
REQ-022 SHALL use a log2(WIDTH)+1 bit iteration counter and leave BUSY for DONE after exactly WIDTH BUSY cycles, so out_valid rises WIDTH+1 cycles after acceptance.
REQ-023 SHALL, for DIVU with b == 0, still take the full WIDTH+1 latency, return result all ones and assert div_by_zero.
REQ-024 SHALL hold out_valid high in DONE, with result, zero and div_by_zero stable, until out_ready is high.
REQ-025 SHALL go DONE->IDLE on the edge where out_valid && out_ready.
REQ-026 SHALL keep out_valid low in IDLE and BUSY.
REQ-027 SHALL compute zero and div_by_zero from the registered result and change them only when entering DONE.
REQ-028 SHALL clear div_by_zero for every op other than DIVU with b == 0.
REQ-029 SHALL ignore in_valid while in BUSY or DONE, and changes to a, b or alu_control after acceptance SHALL NOT affect the result in flight.
REQ-030 SHALL allow out_ready to be high before out_valid; the transfer then completes on the first DONE cycle.
REQ-031 SHALL treat unused alu_control encodings as unreachable; all 8 codes are defined.

Reset
REQ-032 SHALL, while rst_n is low, force state IDLE, in_ready 1, out_valid 0, result 0, zero 1, div_by_zero 0, and clear the iteration counter.
REQ-033 SHALL, when reset is asserted mid-BUSY or in DONE, abandon the operation immediately and never emit its result.
REQ-034 SHALL accept a request on the first rising edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-035 SHALL test single-cycle ops: SUB a=5, b=5 -> out_valid 1 cycle after accept, result 0, zero 1; then ADD 0xFFFFFFFF+1 -> result 0, zero 1.
REQ-036 SHALL test SLT and PASS: SLT a=0xFFFFFFFF, b=1 -> result 1; PASS b=0x12340000 -> result 0x12340000, zero 0.
REQ-037 SHALL test MUL: a=7, b=6 -> in_ready low 32 cycles, out_valid on cycle 33, result 42; and a=0x80000000, b=2 -> result 0.
REQ-038 SHALL test DIVU: a=100, b=7 -> result 14 at cycle 33; a=9, b=0 -> result 0xFFFFFFFF, div_by_zero 1, at cycle 33.
REQ-039 SHALL test backpressure: out_ready held low 10 cycles after a MUL result -> out_valid and result held, in_ready 0 and new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-040 SHALL test reset mid-BUSY: rst_n low at BUSY cycle 10 of a DIVU -> outputs at reset values immediately, no out_valid pulse; after release, ADD 2+3 -> result 5.
